nios2_debug_mem_sequencer: RTL and testbench

- System-clock-side sequencer behind the Nios II JTAG debug slave.
- Takes the one-cycle decoded debug commands (take_action-style strobe plus jdo payload) and runs single-word Avalon-MM transfers into the OCI debug memory.
- Auto-increments the word address after each transfer and holds read results in a MonDReg-style register.
- Drives monitor_ready and monitor_error back to the JTAG side; enforces a bus timeout and flags command overrun.

---
 rtl/nios2_debug_mem_sequencer.sv | 178 +++++++++++++++++
 tb/tb_nios2_debug_mem_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_mem_sequencer.sv
// Purpose: system-clock sequencer that turns decoded JTAG debug commands into single-word Avalon-MM transfers.
// Latency: the request is visible 1 cycle after the strobe; monitor_ready rises 2 cycles after the strobe when the slave has no wait states.
// Backpressure: waitrequest stalls the request up to TIMEOUT cycles; commands that arrive while busy are dropped and flagged in overrun.
module nios2_debug_mem_sequencer #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              overrun,
  output logic              busy
);

  // Command encodings from the debug slave decode logic.
  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_CLRSTAT = 2'b11;

  // The stall counter is wide enough for the largest allowed TIMEOUT.
  localparam int unsigned CNT_W = 16;
  // Counter value seen on the last stalled cycle that is still tolerated.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WR   = 2'b01,
    S_RD   = 2'b10
  } state_t;

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              read_q,    read_d;
  logic              write_q,   write_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] dreg_q,    dreg_d;
  logic              ready_q,   ready_d;
  logic              error_q,   error_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  // State and datapath registers; reset drops any in-flight request without side effects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      dreg_q    <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      dreg_q    <= dreg_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: accept commands in IDLE, run or abandon the bus transfer in WR/RD.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    read_d    = read_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    dreg_d    = dreg_q;
    ready_d   = ready_q;
    error_d   = error_q;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_SETADDR: begin
              addr_d  = cmd_data[ADDR_W-1:0];
              ready_d = 1'b1;
              error_d = 1'b0;
            end
            OP_WRITE: begin
              wdata_d = cmd_data;
              write_d = 1'b1;
              ready_d = 1'b0;
              cnt_d   = '0;
              state_d = S_WR;
            end
            OP_READ: begin
              read_d  = 1'b1;
              ready_d = 1'b0;
              cnt_d   = '0;
              state_d = S_RD;
            end
            OP_CLRSTAT: begin
              error_d   = 1'b0;
              overrun_d = 1'b0;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end

      S_WR, S_RD: begin
        // Any strobe while a transfer is outstanding, even CLRSTAT, is lost.
        if (cmd_valid) begin
          overrun_d = 1'b1;
        end

        if (!avm_waitrequest) begin
          // Transfer accepted by the slave at this edge.
          read_d  = 1'b0;
          write_d = 1'b0;
          addr_d  = addr_q + ADDR_W'(1);
          if (state_q == S_RD) begin
            dreg_d = avm_readdata;
          end
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          // Slave stalled too long: give up, keep address and mon_dreg untouched.
          read_d  = 1'b0;
          write_d = 1'b0;
          error_d = 1'b1;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs come straight from registers so nothing combinational reaches the JTAG side or the bus.
  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign mon_dreg      = dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_nios2_debug_mem_sequencer.sv
// Directed bench for the debug memory sequencer with a transfer scoreboard.
// Expected bus transfers are queued as commands are issued and matched against observed ones.
module tb_nios2_debug_mem_sequencer;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_CLRSTAT = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] mon_dreg;
  logic              monitor_ready;
  logic              monitor_error;
  logic              overrun;
  logic              busy;

  nios2_debug_mem_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .mon_dreg       (mon_dreg),
    .monitor_ready  (monitor_ready),
    .monitor_error  (monitor_error),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } xfer_t;

  int    checks   = 0;
  int    failures = 0;
  xfer_t exp_q[$];
  int    obs_rd   = 0;
  int    r0;

  // Bus monitor state, written only by the monitor process.
  xfer_t obs_log[64];
  int    obs_cnt    = 0;
  int    req_cycles = 0;
  logic  both_seen  = 1'b0;

  // Sample the bus mid-cycle; a request with waitrequest low completes at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (avm_read && avm_write) both_seen = 1'b1;
      if (avm_read || avm_write) begin
        req_cycles++;
        if (!avm_waitrequest && obs_cnt < 64) begin
          obs_log[obs_cnt] = {avm_write, avm_address, (avm_write ? avm_writedata : {DATA_W{1'b0}})};
          obs_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t mk(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    xfer_t x;
    x.wr   = wr;
    x.addr = addr;
    x.data = data;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Issue a command and let the slave stall for the given cycles before answering.
  task automatic do_xfer(input logic [1:0] op, input logic [DATA_W-1:0] d, input int stalls,
                         input logic [DATA_W-1:0] rdata);
    avm_readdata    = rdata;
    avm_waitrequest = (stalls != 0);
    send(op, d);
    repeat (stalls) tick();
    avm_waitrequest = 1'b0;
    tick();
  endtask

  // Match every observed transfer against the queued expectation.
  task automatic drain();
    xfer_t e;
    while (obs_rd < obs_cnt) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 64'(obs_cnt - obs_rd), 64'd0);
        obs_rd = obs_cnt;
      end else begin
        e = exp_q.pop_front();
        chk("xfer_kind",  64'(obs_log[obs_rd].wr),   64'(e.wr));
        chk("xfer_addr",  64'(obs_log[obs_rd].addr), 64'(e.addr));
        chk("xfer_wdata", 64'(obs_log[obs_rd].data), 64'(e.data));
        obs_rd++;
      end
    end
    chk("xfer_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_op          = 2'b00;
    cmd_data        = '0;
    avm_readdata    = '0;
    avm_waitrequest = 1'b0;
    repeat (3) tick();

    chk("rst_address", 64'(avm_address),   64'd0);
    chk("rst_read",    64'(avm_read),      64'd0);
    chk("rst_write",   64'(avm_write),     64'd0);
    chk("rst_wdata",   64'(avm_writedata), 64'd0);
    chk("rst_dreg",    64'(mon_dreg),      64'd0);
    chk("rst_ready",   64'(monitor_ready), 64'd0);
    chk("rst_error",   64'(monitor_error), 64'd0);
    chk("rst_overrun", 64'(overrun),       64'd0);
    chk("rst_busy",    64'(busy),          64'd0);
    reset = 1'b0;

    // Zero-wait write at 0x010.
    send(OP_SETADDR, 32'h0000_0010);
    chk("t1_setaddr", 64'(avm_address),   64'h010);
    chk("t1_setrdy",  64'(monitor_ready), 64'd1);
    exp_q.push_back(mk(1'b1, 9'h010, 32'hDEADBEEF));
    r0 = req_cycles;
    avm_waitrequest = 1'b0;
    send(OP_WRITE, 32'hDEADBEEF);
    chk("t1_write_req",  64'(avm_write),     64'd1);
    chk("t1_write_addr", 64'(avm_address),   64'h010);
    chk("t1_write_data", 64'(avm_writedata), 64'hDEADBEEF);
    chk("t1_ready_low",  64'(monitor_ready), 64'd0);
    chk("t1_busy",       64'(busy),          64'd1);
    tick();
    chk("t1_write_drop", 64'(avm_write),       64'd0);
    chk("t1_addr_inc",   64'(avm_address),     64'h011);
    chk("t1_ready",      64'(monitor_ready),   64'd1);
    chk("t1_idle",       64'(busy),            64'd0);
    chk("t1_req_cycles", 64'(req_cycles - r0), 64'd1);
    drain();

    // Read at the top address with 3 stall cycles; address wraps.
    send(OP_SETADDR, 32'h0000_01FF);
    exp_q.push_back(mk(1'b0, 9'h1FF, 32'h0));
    r0 = req_cycles;
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'hFFFF_0000;
    send(OP_READ, 32'h0);
    chk("t2_read_req", 64'(avm_read),  64'd1);
    chk("t2_no_write", 64'(avm_write), 64'd0);
    repeat (3) tick();
    chk("t2_read_held", 64'(avm_read), 64'd1);
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'h1234_5678;
    tick();
    chk("t2_read_drop",  64'(avm_read),        64'd0);
    chk("t2_req_cycles", 64'(req_cycles - r0), 64'd4);
    chk("t2_dreg",       64'(mon_dreg),        64'h12345678);
    chk("t2_addr_wrap",  64'(avm_address),     64'h000);
    chk("t2_error",      64'(monitor_error),   64'd0);
    chk("t2_ready",      64'(monitor_ready),   64'd1);
    drain();

    // Read that never completes: abandoned on the TIMEOUT-th stalled cycle.
    r0 = req_cycles;
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'h0BAD_0BAD;
    send(OP_READ, 32'h0);
    repeat (TIMEOUT - 1) tick();
    chk("t3_read_held", 64'(avm_read), 64'd1);
    chk("t3_busy_held", 64'(busy),     64'd1);
    tick();
    chk("t3_read_drop",  64'(avm_read),        64'd0);
    chk("t3_req_cycles", 64'(req_cycles - r0), 64'(TIMEOUT));
    chk("t3_error",      64'(monitor_error),   64'd1);
    chk("t3_ready",      64'(monitor_ready),   64'd1);
    chk("t3_addr_hold",  64'(avm_address),     64'h000);
    chk("t3_dreg_hold",  64'(mon_dreg),        64'h12345678);
    chk("t3_idle",       64'(busy),            64'd0);
    avm_waitrequest = 1'b0;
    drain();
    send(OP_CLRSTAT, 32'h0);
    chk("t3_clr_error", 64'(monitor_error), 64'd0);
    chk("t3_clr_ready", 64'(monitor_ready), 64'd1);

    // Write with 5 stalls; extra strobes on stall 2 and on the completion cycle are dropped.
    exp_q.push_back(mk(1'b1, 9'h000, 32'hCAFE_0001));
    r0 = req_cycles;
    avm_waitrequest = 1'b1;
    send(OP_WRITE, 32'hCAFE_0001);
    chk("t4_overrun_clear", 64'(overrun), 64'd0);
    tick();
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_data  = 32'h0BAD_F00D;
    tick();
    cmd_valid = 1'b0;
    chk("t4_overrun_set", 64'(overrun),       64'd1);
    chk("t4_wdata_held",  64'(avm_writedata), 64'hCAFE0001);
    chk("t4_write_held",  64'(avm_write),     64'd1);
    repeat (3) tick();
    avm_waitrequest = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_data  = 32'h0BAD_F00E;
    chk("t4_addr_held", 64'(avm_address), 64'h000);
    tick();
    cmd_valid = 1'b0;
    chk("t4_write_drop",  64'(avm_write),       64'd0);
    chk("t4_addr_inc",    64'(avm_address),     64'h001);
    chk("t4_overrun",     64'(overrun),         64'd1);
    chk("t4_ready",       64'(monitor_ready),   64'd1);
    chk("t4_req_cycles",  64'(req_cycles - r0), 64'd6);
    tick();
    chk("t4_no_2nd_write", 64'(avm_write), 64'd0);
    chk("t4_idle",         64'(busy),      64'd0);
    drain();
    send(OP_CLRSTAT, 32'h0);
    chk("t4_clr_overrun", 64'(overrun), 64'd0);

    // Reset during stall 2 of a read.
    send(OP_SETADDR, 32'h0000_0055);
    avm_waitrequest = 1'b1;
    send(OP_READ, 32'h0);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLRSTAT;
    tick();
    cmd_valid = 1'b0;
    chk("t5_overrun_busy_clr", 64'(overrun), 64'd1);
    reset = 1'b1;
    tick();
    chk("t5_read",    64'(avm_read),      64'd0);
    chk("t5_address", 64'(avm_address),   64'h000);
    chk("t5_ready",   64'(monitor_ready), 64'd0);
    chk("t5_error",   64'(monitor_error), 64'd0);
    chk("t5_overrun", 64'(overrun),       64'd0);
    chk("t5_busy",    64'(busy),          64'd0);
    chk("t5_dreg",    64'(mon_dreg),      64'd0);
    reset           = 1'b0;
    avm_waitrequest = 1'b0;
    drain();

    // Back-to-back reads from 0x020.
    send(OP_SETADDR, 32'h0000_0020);
    exp_q.push_back(mk(1'b0, 9'h020, 32'h0));
    do_xfer(OP_READ, 32'h0, 0, 32'h0000_00A0);
    chk("t6_dreg0", 64'(mon_dreg),    64'hA0);
    chk("t6_addr0", 64'(avm_address), 64'h021);
    drain();
    exp_q.push_back(mk(1'b0, 9'h021, 32'h0));
    do_xfer(OP_READ, 32'h0, 1, 32'h0000_00A1);
    chk("t6_dreg1",   64'(mon_dreg),      64'hA1);
    chk("t6_addr1",   64'(avm_address),   64'h022);
    chk("t6_overrun", 64'(overrun),       64'd0);
    chk("t6_ready",   64'(monitor_ready), 64'd1);
    drain();

    chk("rd_wr_exclusive", 64'(both_seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
